// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : M-stage data access controller bridging load/store requests
//               to a split address/data handshake bus (strobes, lane
//               replication, load extension, misalignment detection, stall).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall_o,
    output logic              addr_err_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ADDR  = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    logic [2:0]  r_state;
    logic        r_unsigned;

    logic        w_sizeHalf;
    logic        w_sizeWord;
    logic        w_go;
    logic        w_complete;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldData;

    assign w_sizeHalf = (req_size == 2'b01);
    assign w_sizeWord = req_size[1];
    assign addr_err_o = req_valid & ((w_sizeHalf & req_addr[0]) |
                                     (w_sizeWord & (req_addr[1:0] != 2'b00)));
    assign w_go       = req_valid & ~addr_err_o & ~flush;

    // Read data is only committed for a transaction that was not flushed.
    assign w_complete = ~flush & data_data_ok &
                        (((r_state == c_ADDR) & data_addr_ok) | (r_state == c_DATA));

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
        if (!req_wr) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        case (data_addr[1:0])
            2'd0:    w_byte = data_rdata[7:0];
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (data_size)
            2'b00:   w_ldData = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_ldData = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_ldData = data_rdata;
        endcase
    end

    always_comb begin
        case (r_state)
            c_IDLE:  stall_o = w_go;
            c_ADDR:  stall_o = 1'b1;
            c_DATA:  stall_o = 1'b1;
            c_DRAIN: stall_o = req_valid;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_unsigned  <= 1'b0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'b00;
            data_addr   <= '0;
            data_wstrb  <= 4'b0000;
            data_wdata  <= 32'h0;
            rdata_o     <= 32'h0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_go) begin
                        data_req   <= 1'b1;
                        data_wr    <= req_wr;
                        data_size  <= req_size;
                        data_addr  <= req_addr;
                        data_wstrb <= w_wstrb;
                        data_wdata <= w_wdata;
                        r_unsigned <= req_unsigned;
                        r_state    <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    // An accepted address cannot be withdrawn, so a flush
                    // coinciding with addr_ok still has to drain its data phase.
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            r_state <= flush ? c_IDLE : c_DONE;
                        end else begin
                            r_state <= flush ? c_DRAIN : c_DATA;
                        end
                    end else if (flush) begin
                        data_req <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                c_DATA: begin
                    if (data_data_ok) begin
                        r_state <= flush ? c_IDLE : c_DONE;
                    end else if (flush) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                c_DRAIN: begin
                    if (data_data_ok) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
            if (w_complete && !data_wr) begin
                rdata_o     <= w_ldData;
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Cycle-by-cycle vector table plus a delayed-handshake sequence
//               for mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall_o, addr_err_o, rdata_valid;
    logic [31:0] rdata_o;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    int nVec = 0;
    int nMis = 0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush), .stall_o(stall_o), .addr_err_o(addr_err_o),
        .rdata_o(rdata_o), .rdata_valid(rdata_valid),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, valid, wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata;
        logic        flush, aok, dok;
        logic [31:0] rdata;
        logic        eStall, eErr, eReq, eRv;
        logic        chk, eWr;
        logic [3:0]  eStrb;
        logic [31:0] eWdata, eRdata;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, va, wr, input logic [1:0] sz, input logic un,
                     input logic [31:0] ad, wd, input logic fl, ao, dk,
                     input logic [31:0] rd, input logic eS, eE, eQ, eR,
                     input logic ck, eW, input logic [3:0] eB,
                     input logic [31:0] eD, eRd);
        vec_t t;
        t = '{rst:r, valid:va, wr:wr, size:sz, uns:un, addr:ad, wdata:wd,
              flush:fl, aok:ao, dok:dk, rdata:rd, eStall:eS, eErr:eE, eReq:eQ,
              eRv:eR, chk:ck, eWr:eW, eStrb:eB, eWdata:eD, eRdata:eRd};
        vq.push_back(t);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        bit seen;
        // rst valid wr size uns addr wdata flush aok dok rdata | stall err req rv | chk wr strb wdata rdata
        v(1,0,0,B,0,32'h0,32'h0,0,0,0,32'h0,              0,0,0,0, 1,0,4'h0,32'h0,32'h0);
        // word load, zero-wait bus
        v(0,1,0,W,0,32'h10000004,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h10000004,32'h0,0,1,1,32'h87654321, 1,0,1,0, 1,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h10000004,32'h0,0,0,0,32'h0,        0,0,0,1, 1,0,4'h0,32'h0,32'h87654321);
        // byte store 0xAB to offset 2
        v(0,1,1,B,0,32'h10000002,32'hAB,0,0,0,32'h0,       1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,1,B,0,32'h10000002,32'hAB,0,1,0,32'h0,       1,0,1,0, 1,1,4'h4,32'hABABABAB,32'h87654321);
        v(0,1,1,B,0,32'h10000002,32'hAB,0,0,1,32'h0,       1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,1,B,0,32'h10000002,32'hAB,0,0,0,32'h0,       0,0,0,0, 1,1,4'h4,32'hABABABAB,32'h87654321);
        // LB / LBU at lane 3, LH at upper half
        v(0,1,0,B,0,32'h20000003,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,B,0,32'h20000003,32'h0,0,1,1,32'h80123456, 1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,B,0,32'h20000003,32'h0,0,0,0,32'h0,        0,0,0,1, 1,0,4'h0,32'h0,32'hFFFFFF80);
        v(0,1,0,B,1,32'h20000003,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,B,1,32'h20000003,32'h0,0,1,1,32'h80123456, 1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,B,1,32'h20000003,32'h0,0,0,0,32'h0,        0,0,0,1, 1,0,4'h0,32'h0,32'h00000080);
        v(0,1,0,H,0,32'h20000002,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,H,0,32'h20000002,32'h0,0,1,1,32'h80011234, 1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,H,0,32'h20000002,32'h0,0,0,0,32'h0,        0,0,0,1, 1,0,4'h0,32'h0,32'hFFFF8001);
        // misaligned half load and word store never reach the bus
        v(0,1,0,H,0,32'h30000001,32'h0,0,0,0,32'h0,        0,1,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,1,W,0,32'h30000002,32'h12345678,0,0,0,32'h0, 0,1,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,0,0,B,0,32'h0,32'h0,0,0,0,32'h0,              0,0,0,0, 1,0,4'h0,32'h0,32'hFFFF8001);
        // word store with addr_ok delayed 3 cycles
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,0,32'h0, 1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,0,32'h0, 1,0,1,0, 1,1,4'hF,32'hDEADBEEF,32'hFFFF8001);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,0,32'h0, 1,0,1,0, 1,1,4'hF,32'hDEADBEEF,32'hFFFF8001);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,0,32'h0, 1,0,1,0, 1,1,4'hF,32'hDEADBEEF,32'hFFFF8001);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,1,0,32'h0, 1,0,1,0, 1,1,4'hF,32'hDEADBEEF,32'hFFFF8001);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,1,32'h0, 1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,1,W,0,32'h40000008,32'hDEADBEEF,0,0,0,32'h0, 0,0,0,0, 1,1,4'hF,32'hDEADBEEF,32'hFFFF8001);
        // load flushed in its 2nd ADDR cycle
        v(0,1,0,W,0,32'h40000010,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h40000010,32'h0,0,0,0,32'h0,        1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h40000010,32'h0,1,0,0,32'h0,        1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,0,0,W,0,32'h0,32'h0,0,0,0,32'h0,              0,0,0,0, 1,0,4'h0,32'h0,32'hFFFF8001);
        // flush in DATA, new load waits through DRAIN
        v(0,1,0,W,0,32'h50000000,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h50000000,32'h0,0,1,0,32'h0,        1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h50000000,32'h0,1,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h60000004,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h60000004,32'h0,0,0,1,32'hBADBAD00, 1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h60000004,32'h0,0,0,0,32'h0,        1,0,0,0, 1,0,4'h0,32'h0,32'hFFFF8001);
        v(0,1,0,W,0,32'h60000004,32'h0,0,1,1,32'h11223344, 1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h60000004,32'h0,0,0,0,32'h0,        0,0,0,1, 1,0,4'h0,32'h0,32'h11223344);
        // flush and data_ok together in DATA: result discarded
        v(0,1,0,W,0,32'h70000000,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h70000000,32'h0,0,1,0,32'h0,        1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,1,0,W,0,32'h70000000,32'h0,1,0,1,32'hCAFEF00D, 1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(0,0,0,W,0,32'h0,32'h0,0,0,0,32'h0,              0,0,0,0, 1,0,4'h0,32'h0,32'h11223344);
        // reset in the middle of a transaction
        v(0,1,0,W,0,32'h70000004,32'h0,0,0,0,32'h0,        1,0,0,0, 0,0,4'h0,32'h0,32'h0);
        v(1,1,0,W,0,32'h70000004,32'h0,0,0,0,32'h0,        1,0,1,0, 0,0,4'h0,32'h0,32'h0);
        v(0,0,0,B,0,32'h0,32'h0,0,0,0,32'h0,              0,0,0,0, 1,0,4'h0,32'h0,32'h0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst          = vq[i].rst;
            req_valid    = vq[i].valid;
            req_wr       = vq[i].wr;
            req_size     = vq[i].size;
            req_unsigned = vq[i].uns;
            req_addr     = vq[i].addr;
            req_wdata    = vq[i].wdata;
            flush        = vq[i].flush;
            data_addr_ok = vq[i].aok;
            data_data_ok = vq[i].dok;
            data_rdata   = vq[i].rdata;
            #1;
            nVec++;
            check("stall_o", i, 32'(stall_o), 32'(vq[i].eStall));
            check("addr_err_o", i, 32'(addr_err_o), 32'(vq[i].eErr));
            check("data_req", i, 32'(data_req), 32'(vq[i].eReq));
            check("rdata_valid", i, 32'(rdata_valid), 32'(vq[i].eRv));
            if (vq[i].chk) begin
                check("data_wr", i, 32'(data_wr), 32'(vq[i].eWr));
                check("data_wstrb", i, 32'(data_wstrb), 32'(vq[i].eStrb));
                check("data_wdata", i, data_wdata, vq[i].eWdata);
                check("rdata_o", i, rdata_o, vq[i].eRdata);
            end
        end

        // LHU at upper half, addr_ok after 3 ADDR cycles, data_ok one cycle later
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            rst          = 1'b0;
            req_valid    = 1'b1;
            req_wr       = 1'b0;
            req_size     = H;
            req_unsigned = 1'b1;
            req_addr     = 32'h80000006;
            req_wdata    = 32'h0;
            flush        = 1'b0;
            data_addr_ok = (k == 3);
            data_data_ok = (k == 4);
            data_rdata   = 32'h80015555;
            #1;
            if (data_req) begin
                nVec++;
                check("hold_addr", 100 + k, data_addr, 32'h80000006);
                check("hold_size", 100 + k, 32'(data_size), 32'(H));
                check("hold_stall", 100 + k, 32'(stall_o), 32'd1);
            end
            if (rdata_valid) begin
                seen = 1'b1;
                nVec++;
                check("lhu_rdata", 100 + k, rdata_o, 32'h00008001);
                check("lhu_stall", 100 + k, 32'(stall_o), 32'd0);
                check("lhu_cycle", 100 + k, 32'(k), 32'd5);
            end
        end
        if (!seen) begin
            nMis++;
            $display("FAIL lhu_timeout: rdata_valid got 0 expected 1 within 30 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data access controller. Sits directly downstream of the datapath's M-stage outputs (ALU address, store data, access size) and bridges them to an SRAM-like data bus with a split address/data handshake.
- Generates byte strobes and lane-replicated store data, and extracts and extends load data.
- Detects misaligned accesses.
- Raises a pipeline stall while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, width of the request and bus address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  M stage holds a load/store this cycle
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word (11 is treated as word)
- req_unsigned  in  1  zero-extend the load result (LBU/LHU)
- req_addr  in  ADDR_W  byte address (aluoutM)
- req_wdata  in  32  unaligned store data, value in the low bits (writedataM)
- flush  in  1  exception flush; cancels the current request
- stall_o  out  1  hold the pipeline
- addr_err_o  out  1  misaligned access, combinational from the req_* inputs
- rdata_o  out  32  extended load result
- rdata_valid  out  1  rdata_o is valid for the held load
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size (copy of the latched req_size)
- data_addr  out  ADDR_W  bus address
- data_wstrb  out  4  byte enables; 0 for loads
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data returned / write completed
- data_rdata  in  32  raw bus read word

Behaviour:
- Reset (synchronous, rst=1 at the clk edge):
  - state=IDLE.
  - All registered outputs are 0: data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, rdata_o, rdata_valid.
  - rst has priority over every other input.
- addr_err_o:
  - 1 when req_valid & ((size=half & addr[0]) | (size=word & addr[1:0]!=0)).
  - A misaligned request never reaches the bus and never stalls.
- Lane mapping, computed at issue:
  - byte: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111, wdata = wdata.
  - load: wstrb = 0000.
- State machine with states IDLE, ADDR, DATA, DONE, DRAIN:
  - IDLE:
    - go = req_valid & ~addr_err_o & ~flush.
    - On go: latch addr, size, wr, unsigned and the lane-mapped data; set data_req=1; go to ADDR.
  - ADDR:
    - data_req is held at 1 with stable fields.
    - On data_addr_ok: data_req=0. Then data_data_ok in the same cycle goes to DONE; otherwise go to DATA.
    - On flush without data_addr_ok: data_req=0, go to IDLE (request abandoned).
  - DATA:
    - On data_data_ok: go to DONE.
    - On flush without data_data_ok: go to DRAIN.
    - On flush and data_data_ok in the same cycle: go to IDLE, result discarded.
  - DONE:
    - Lasts one cycle with rdata_valid=1 (loads only) and stall_o=0.
    - The pipeline advances at the end of this cycle; always return to IDLE.
  - DRAIN:
    - Waits for data_data_ok of the cancelled transaction, discards data, then goes to IDLE.
    - rdata_valid stays 0.
- stall_o (combinational) is 1 when any of the following holds:
  - state is IDLE and go;
  - state is ADDR;
  - state is DATA;
  - state is DRAIN and req_valid.
- Load extraction, registered at the data_data_ok edge using the latched addr[1:0]:
  - byte: selected lane, sign- or zero-extended per req_unsigned.
  - half: lane chosen by addr[1], extended per req_unsigned.
  - word: raw word.
  - Stores leave rdata_o unchanged; rdata_valid=0.
- Minimum load latency with a zero-wait bus: request in cycle 0, addr_ok and data_ok in cycle 1, DONE in cycle 2. stall_o is high in cycles 0–1.
- rst asserted mid-transaction returns to IDLE immediately. The bus is expected to be reset together with this block.

Test Plan:
- Word load, addr 0x1000_0004, addr_ok and data_ok in the same cycle, rdata 0x8765_4321 -> stall_o high for 2 cycles; DONE cycle shows rdata_o=0x8765_4321, rdata_valid=1.
- Byte store 0xAB to 0x...0002 -> data_wstrb=0100, data_wdata=0xABAB_ABAB, data_wr=1; rdata_valid stays 0.
- LB and LBU at addr[1:0]=3 with rdata 0x80xx_xxxx -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080. LH at addr[1]=1 with rdata 0x8001_xxxx -> 0xFFFF_8001.
- Half load at 0x...0001 and word store at 0x...0002 -> addr_err_o=1, data_req stays 0, stall_o=0.
- addr_ok delayed 3 cycles -> data_req and all fields stable throughout; flush in the 2nd ADDR cycle -> data_req drops next cycle, state IDLE, no rdata_valid.
- Flush while in DATA, data_ok arriving 2 cycles later, new load pending -> DRAIN; stall_o held until that data_ok; old data discarded; the new load then issues from IDLE.
